serial_subtractor: RTL

Bit-serial two's-complement subtractor that computes DIFF = A - B - borrow_in, processing one bit per clock, LSB first.
- Each bit is computed by a combinational full-subtractor cell.
- Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake.
- Sits beside the arithmetic cells in the datapath library. It is the area-optimised counterpart for subtract/compare operations where latency is acceptable.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 98 +++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and helpers for the serial arithmetic cells.
package arith_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sub_state_e;

    // Bit-counter width for a given operand width, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        int unsigned w;
        if (width <= 1) begin
            w = 1;
        end else begin
            w = $clog2(width);
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    modport master (
        output in_valid, a_in, b_in, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, ovf
    );

    modport slave (
        input  in_valid, a_in, b_in, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, ovf
    );
endinterface

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout is the borrow.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrow_in, LSB first, one bit per clock.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CntW = cnt_w(WIDTH);

    sub_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             bor_q, bor_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             d_bit, bout_bit;

    full_subtractor u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (bor_q),
        .d_o    (d_bit),
        .bout_o (bout_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bor_d   = bor_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StRun;
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    bor_d   = bus.borrow_in;
                    cnt_d   = '0;
                    // Operand signs are lost to shifting, so keep them for ovf.
                    a_msb_d = bus.a_in[WIDTH-1];
                    b_msb_d = bus.b_in[WIDTH-1];
                end
            end
            StRun: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = d_bit;
                bor_d            = bout_bit;
                cnt_d            = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bor_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.diff       = res_q;
    assign bus.borrow_out = bor_q;
    assign bus.ovf        = (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);

endmodule
